// File: rtl/fnd_scan_controller_if.sv
// Stopwatch-to-display bus for the FND scan controller.
//   sw0      : display mode select (0 = sec.msec, 1 = hour.min)
//   msec     : centiseconds, nominal 0-99
//   sec      : seconds, nominal 0-59
//   min      : minutes, nominal 0-59
//   hour     : hours, nominal 0-23
//   fnd_com  : active-low one-hot digit enables, bit3 = leftmost digit
//   fnd_data : active-low segments {dp,g,f,e,d,c,b,a}
// master = time source / display sink, slave = scan controller.
interface fnd_scan_controller_if;
   logic       sw0;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   modport master (
      output sw0, msec, sec, min, hour,
      input  fnd_com, fnd_data
   );

   modport slave (
      input  sw0, msec, sec, min, hour,
      output fnd_com, fnd_data
   );
endinterface

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scan controller for the stopwatch.
// Time-multiplexes the digits at SCAN_HZ, selects sec.msec or hour.min
// from sw0, blinks the sel2 decimal point at 1 Hz and latches a per-frame
// snapshot of the time inputs so a frame never mixes two time values.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : fnd_scan_controller_if.slave (time inputs in, fnd_com/fnd_data out)
// Parameters: CLK_FREQ (Hz), SCAN_HZ (digit advance rate, Hz).
// CLK_FREQ/SCAN_HZ must be at least 2.

// Single-digit 7-segment decoder, active-low, dp off. Values >9 show a dash.
module fnd_seg_decode (
   input  logic [3:0] digit,
   output logic [7:0] seg
);
   always_comb begin
      seg = 8'hBF;
      case (digit)
         4'd0: seg = 8'hC0;
         4'd1: seg = 8'hF9;
         4'd2: seg = 8'hA4;
         4'd3: seg = 8'hB0;
         4'd4: seg = 8'h99;
         4'd5: seg = 8'h92;
         4'd6: seg = 8'h82;
         4'd7: seg = 8'hF8;
         4'd8: seg = 8'h80;
         4'd9: seg = 8'h90;
         default: seg = 8'hBF;
      endcase
   end
endmodule

module fnd_scan_controller #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int SCAN_HZ  = 1000
) (
   input logic                  clk,
   input logic                  rst,
   fnd_scan_controller_if.slave bus
);
   localparam int TICK_DIV   = CLK_FREQ / SCAN_HZ;
   localparam int CNT_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int NUM_DIGITS = 4;

   logic [CNT_W-1:0] tick_cnt;
   logic [1:0]       sel;
   logic             tick;
   logic             wrap;
   logic [1:0]       sel_nxt;

   logic       snap_sw0;
   logic [6:0] snap_msec;
   logic [5:0] snap_sec;
   logic [5:0] snap_min;
   logic [4:0] snap_hour;

   logic       snap_sw0_nxt;
   logic [6:0] snap_msec_nxt;
   logic [5:0] snap_sec_nxt;
   logic [5:0] snap_min_nxt;
   logic [4:0] snap_hour_nxt;

   logic [6:0] lo_val;
   logic [5:0] hi_val;

   logic [NUM_DIGITS-1:0][3:0] digit;
   logic [NUM_DIGITS-1:0][7:0] seg;

   logic [3:0] com_nxt;
   logic [7:0] data_nxt;
   logic [3:0] com_q;
   logic [7:0] data_q;

   assign tick    = (tick_cnt == CNT_W'(TICK_DIV - 1));
   assign wrap    = tick && (sel == 2'd3);
   assign sel_nxt = tick ? sel + 2'd1 : sel;

   // Outputs are registered on the tick edge itself, so they are decoded
   // from the post-tick sel and snapshot. On the wrap tick this means the
   // freshly captured inputs feed the sel0 digit of the new frame.
   assign snap_sw0_nxt  = wrap ? bus.sw0  : snap_sw0;
   assign snap_msec_nxt = wrap ? bus.msec : snap_msec;
   assign snap_sec_nxt  = wrap ? bus.sec  : snap_sec;
   assign snap_min_nxt  = wrap ? bus.min  : snap_min;
   assign snap_hour_nxt = wrap ? bus.hour : snap_hour;

   // Low pair of digits is msec or min, high pair is sec or hour.
   assign lo_val = snap_sw0_nxt ? {1'b0, snap_min_nxt}  : snap_msec_nxt;
   assign hi_val = snap_sw0_nxt ? {1'b0, snap_hour_nxt} : snap_sec_nxt;

   // Max tens value is 127/10 = 12, so 4 bits per digit is enough and lets
   // an out-of-range msec reach the decoder's dash case.
   assign digit[0] = 4'(lo_val % 7'd10);
   assign digit[1] = 4'(lo_val / 7'd10);
   assign digit[2] = 4'(hi_val % 6'd10);
   assign digit[3] = 4'(hi_val / 6'd10);

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      fnd_seg_decode u_dec (
         .digit (digit[d]),
         .seg   (seg[d])
      );
   end

   always_comb begin
      com_nxt  = ~(4'b0001 << sel_nxt);
      data_nxt = seg[sel_nxt];
      // dp on sel2 only: lit for the first half of each second.
      if (sel_nxt == 2'd2 && snap_msec_nxt < 7'd50)
         data_nxt[7] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_cnt  <= '0;
         sel       <= 2'd0;
         snap_sw0  <= 1'b0;
         snap_msec <= '0;
         snap_sec  <= '0;
         snap_min  <= '0;
         snap_hour <= '0;
         com_q     <= 4'b1111;
         data_q    <= 8'hFF;
      end else begin
         tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
         sel       <= sel_nxt;
         snap_sw0  <= snap_sw0_nxt;
         snap_msec <= snap_msec_nxt;
         snap_sec  <= snap_sec_nxt;
         snap_min  <= snap_min_nxt;
         snap_hour <= snap_hour_nxt;
         if (tick) begin
            com_q  <= com_nxt;
            data_q <= data_nxt;
         end
      end
   end

   assign bus.fnd_com  = com_q;
   assign bus.fnd_data = data_q;
endmodule
